// File: rtl/knn_vote_pkg.sv
// Shared definitions for the KNN vote block: list geometry, the invalid-distance
// marker, FSM state encoding and entry field-extract helpers (also used by the
// insert datapath).
package knn_vote_pkg;

  localparam int DATA_W = 32;
  localparam int C      = 8;
  localparam int K      = 4;
  localparam int NCLASS = 16;
  localparam int E      = DATA_W + C;
  localparam int LIST_W = K * E;
  localparam int CNT_W  = $clog2(K + 1);
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int CLS_W  = (NCLASS > 1) ? $clog2(NCLASS) : 1;

  // An entry whose distance is all-ones has never been filled.
  localparam logic [DATA_W-1:0] INVALID_DIST = {DATA_W{1'b1}};
  localparam logic [C-1:0]      NCLASS_L     = C'(NCLASS);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(K - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Entry i of the packed list; entry 0 (nearest) sits at the MSB end.
  function automatic logic [E-1:0] get_entry(input logic [LIST_W-1:0] list, input int i);
    return list[(K-1-i)*E +: E];
  endfunction

  function automatic logic [DATA_W-1:0] entry_dist(input logic [E-1:0] e);
    return e[E-1:C];
  endfunction

  function automatic logic [C-1:0] entry_label(input logic [E-1:0] e);
    return e[C-1:0];
  endfunction

endpackage

// File: rtl/knn_vote_if.sv
// Request/result bundle between the neighbour-list side and the vote engine.
interface knn_vote_if;
  import knn_vote_pkg::*;

  logic                start;
  logic [LIST_W-1:0]   nb_list;
  logic                busy;
  logic                done;
  logic [C-1:0]        label;
  logic [CNT_W-1:0]    votes;
  logic                valid;
  logic                bad_label;

  modport master (
    output start, nb_list,
    input  busy, done, label, votes, valid, bad_label
  );

  modport slave (
    input  start, nb_list,
    output busy, done, label, votes, valid, bad_label
  );
endinterface

// File: rtl/knn_vote_bank.sv
// Per-class vote counters. One counter may be bumped per cycle; the bumped
// value is also registered on rd_cnt so the caller can compare it next cycle.
module knn_vote_bank
  import knn_vote_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CLS_W-1:0] inc_idx,
  output logic [CNT_W-1:0] rd_cnt
);

  logic [CNT_W-1:0] cnt [NCLASS];

  // Counter array with synchronous clear and single-index increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCLASS; i++) cnt[i] <= '0;
      rd_cnt <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCLASS; i++) cnt[i] <= '0;
      rd_cnt <= '0;
    end else if (inc) begin
      cnt[inc_idx] <= cnt[inc_idx] + CNT_W'(1);
      rd_cnt       <= cnt[inc_idx] + CNT_W'(1);
    end
  end

endmodule

// File: rtl/knn_vote.sv
// KNN majority vote: snapshots the neighbour list on start, scans one entry per
// clock, tallies votes per class and reports the first class (in index order)
// to reach the highest count.
module knn_vote
  import knn_vote_pkg::*;
(
  input logic       clk,
  input logic       rst,
  knn_vote_if.slave bus
);

  state_t           state;
  logic [E-1:0]     snap [K];
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] best_cnt;
  logic [C-1:0]     best_label;
  // The bank's count lands one cycle after the vote, so that vote's label is
  // remembered here and compared against best one cycle later.
  logic             pend;
  logic [C-1:0]     pend_label;

  logic [E-1:0]      cur_entry;
  logic [DATA_W-1:0] cur_dist;
  logic [C-1:0]      cur_label;
  logic              cur_vote;
  logic              cur_bad;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  nb_cnt;
  logic [C-1:0]      nb_label;
  logic              bank_clr;

  assign bank_clr = (state == ST_IDLE) && bus.start;

  knn_vote_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .clr     (bank_clr),
    .inc     (cur_vote),
    .inc_idx (cur_label[CLS_W-1:0]),
    .rd_cnt  (rd_cnt)
  );

  // Classify the current entry and fold the pending vote into the best so far.
  always_comb begin
    cur_entry = snap[idx];
    cur_dist  = entry_dist(cur_entry);
    cur_label = entry_label(cur_entry);
    cur_vote  = 1'b0;
    cur_bad   = 1'b0;
    if ((state == ST_SCAN) && (cur_dist != INVALID_DIST)) begin
      if (cur_label < NCLASS_L) begin
        cur_vote = 1'b1;
      end else begin
        cur_bad = 1'b1;
      end
    end else begin
      cur_vote = 1'b0;
    end

    nb_cnt   = best_cnt;
    nb_label = best_label;
    if (pend && (rd_cnt > best_cnt)) begin
      nb_cnt   = rd_cnt;
      nb_label = pend_label;
    end else begin
      nb_cnt   = best_cnt;
      nb_label = best_label;
    end
  end

  // Control FSM, best tracking and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      for (int i = 0; i < K; i++) snap[i] <= '0;
      best_cnt      <= '0;
      best_label    <= '0;
      pend          <= 1'b0;
      pend_label    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.label     <= '0;
      bus.votes     <= '0;
      bus.valid     <= 1'b0;
      bus.bad_label <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < K; i++) snap[i] <= get_entry(bus.nb_list, i);
            idx           <= '0;
            best_cnt      <= '0;
            best_label    <= '0;
            pend          <= 1'b0;
            bus.bad_label <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          best_cnt   <= nb_cnt;
          best_label <= nb_label;
          pend       <= cur_vote;
          pend_label <= cur_label;
          if (cur_bad) bus.bad_label <= 1'b1;
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          best_cnt   <= nb_cnt;
          best_label <= nb_label;
          pend       <= 1'b0;
          bus.label  <= nb_label;
          bus.votes  <= nb_cnt;
          bus.valid  <= (nb_cnt != '0);
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote: directed plan cases, robustness scenarios
// and randomized lists checked against a counting reference model.
module tb_knn_vote;
  import knn_vote_pkg::*;

  typedef logic [DATA_W-1:0] dist_t [K];
  typedef logic [C-1:0]      lab_t  [K];

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  knn_vote_if bus ();
  knn_vote dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [LIST_W-1:0] pack_list(input dist_t d, input lab_t l);
    logic [LIST_W-1:0] r;
    r = '0;
    for (int i = 0; i < K; i++) r[(K-1-i)*E +: E] = {d[i], l[i]};
    return r;
  endfunction

  // Reference: tally all legal valid entries, find the maximum, then replay in
  // index order and pick the first class whose running count hits that maximum.
  function automatic void ref_vote(input dist_t d, input lab_t l, output int w_label,
                                   output int w_votes, output bit w_valid, output bit w_bad);
    int tally [NCLASS];
    int run   [NCLASS];
    int mx;
    bit found;
    mx = 0; found = 1'b0; w_bad = 1'b0; w_label = 0;
    for (int c = 0; c < NCLASS; c++) begin tally[c] = 0; run[c] = 0; end
    for (int i = 0; i < K; i++)
      if (d[i] != INVALID_DIST) begin
        if (int'(l[i]) < NCLASS) tally[l[i]]++;
        else w_bad = 1'b1;
      end
    for (int c = 0; c < NCLASS; c++) if (tally[c] > mx) mx = tally[c];
    w_votes = mx;
    w_valid = (mx > 0);
    for (int i = 0; i < K; i++)
      if (d[i] != INVALID_DIST && int'(l[i]) < NCLASS) begin
        run[l[i]]++;
        if (!found && run[l[i]] == mx) begin w_label = int'(l[i]); found = 1'b1; end
      end
  endfunction

  // Pulse start with the given list and wait (bounded) for done; lat = -1 on timeout.
  task automatic run_vote(input logic [LIST_W-1:0] list, output int lat);
    @(posedge clk); #1;
    bus.nb_list = list;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus.done) lat = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.nb_list = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.label, bus.votes, bus.valid, bus.bad_label} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b label=%0d votes=%0d valid=%b bad=%b exp all 0",
               bus.busy, bus.done, bus.label, bus.votes, bus.valid, bus.bad_label);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    dist_t d;
    lab_t  l;
    int    lat;
    int    e_lab [5] = '{3, 3, 0, 9, 4};
    int    e_vot [5] = '{2, 2, 0, 1, 2};
    bit    e_val [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit    e_bad [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 5; t++) begin
      case (t)
        0: begin d = '{32'd10, 32'd20, 32'd30, 32'd40}; l = '{8'd3, 8'd5, 8'd3, 8'd7}; end
        1: begin d = '{32'd10, 32'd20, 32'd30, 32'd40}; l = '{8'd5, 8'd3, 8'd3, 8'd5}; end
        2: begin d = '{INVALID_DIST, INVALID_DIST, INVALID_DIST, INVALID_DIST}; l = '{8'd1, 8'd2, 8'd3, 8'd4}; end
        3: begin d = '{32'd4, 32'd8, INVALID_DIST, INVALID_DIST}; l = '{8'd9, 8'd2, 8'd2, 8'd2}; end
        default: begin d = '{32'd1, 32'd2, 32'd3, 32'd4}; l = '{8'd20, 8'd4, 8'd4, 8'd1}; end
      endcase
      run_vote(pack_list(d, l), lat);
      checks++;
      if (lat !== K + 1) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=%0d", t, lat, K + 1); end
      checks++;
      if ({int'(bus.label), int'(bus.votes)} !== {e_lab[t], e_vot[t]}) begin
        failures++;
        $display("FAIL directed%0d_result got label=%0d votes=%0d exp label=%0d votes=%0d",
                 t, bus.label, bus.votes, e_lab[t], e_vot[t]);
      end
      checks++;
      if ({bus.valid, bus.bad_label} !== {e_val[t], e_bad[t]}) begin
        failures++;
        $display("FAIL directed%0d_flags got valid=%b bad=%b exp valid=%b bad=%b",
                 t, bus.valid, bus.bad_label, e_val[t], e_bad[t]);
      end
    end
  endtask

  // Re-pulse start during SCAN and during DONE: exactly one done, first list's result.
  task automatic test_restart_ignored();
    dist_t d, d2;
    lab_t  l, l2;
    int    ndone, first;
    d  = '{32'd1, 32'd2, 32'd3, 32'd4}; l  = '{8'd6, 8'd6, 8'd1, 8'd2};
    d2 = '{32'd1, 32'd2, 32'd3, 32'd4}; l2 = '{8'd8, 8'd8, 8'd8, 8'd8};
    @(posedge clk); #1;
    bus.nb_list = pack_list(d, l); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0; first = -1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", bus.busy); end
      end
      if (bus.done) begin ndone++; if (first < 0) first = c; end
      bus.start = (c == 2 || c == 4);
      if (c == 2) bus.nb_list = pack_list(d2, l2);
    end
    checks++;
    if (ndone !== 1 || first !== K + 1) begin
      failures++;
      $display("FAIL restart_done got count=%0d at=%0d exp count=1 at=%0d", ndone, first, K + 1);
    end
    checks++;
    if ({int'(bus.label), int'(bus.votes), bus.busy} !== {32'd6, 32'd2, 1'b0}) begin
      failures++;
      $display("FAIL restart_result got label=%0d votes=%0d busy=%b exp label=6 votes=2 busy=0",
               bus.label, bus.votes, bus.busy);
    end
  endtask

  // Change nb_list right after the start edge; result must come from the snapshot.
  task automatic test_list_change();
    dist_t d;
    lab_t  l, l2;
    int    lat;
    d  = '{32'd5, 32'd6, 32'd7, 32'd8};
    l  = '{8'd11, 8'd2, 8'd11, 8'd2};
    l2 = '{8'd1, 8'd1, 8'd1, 8'd1};
    @(posedge clk); #1;
    bus.nb_list = pack_list(d, l); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.nb_list = pack_list(d, l2);
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus.done) lat = c;
    end
    checks++;
    if ({lat, int'(bus.label), int'(bus.votes)} !== {K + 1, 32'd11, 32'd2}) begin
      failures++;
      $display("FAIL list_change got lat=%0d label=%0d votes=%0d exp lat=%0d label=11 votes=2",
               lat, bus.label, bus.votes, K + 1);
    end
  endtask

  // Assert reset two cycles into a vote after a result with bad_label set.
  task automatic test_reset_mid();
    dist_t d;
    lab_t  l;
    int    lat, ndone;
    d = '{32'd1, 32'd2, 32'd3, 32'd4}; l = '{8'd7, 8'd30, 8'd7, 8'd7};
    run_vote(pack_list(d, l), lat);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.label, bus.votes, bus.valid, bus.bad_label} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got busy=%b label=%0d votes=%0d valid=%b bad=%b exp all 0",
               bus.busy, bus.label, bus.votes, bus.valid, bus.bad_label);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d exp=0", ndone); end
  endtask

  // Randomized lists back to back, each checked against the reference, plus hold.
  task automatic test_random();
    dist_t d;
    lab_t  l;
    int    lat, e_lab, e_vot;
    bit    e_val, e_bad;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < K; i++) begin
        d[i] = ($urandom_range(0, 3) == 0) ? INVALID_DIST : DATA_W'($urandom_range(0, 1000));
        l[i] = ($urandom_range(0, 7) == 0) ? C'($urandom_range(16, 255)) : C'($urandom_range(0, 4));
      end
      ref_vote(d, l, e_lab, e_vot, e_val, e_bad);
      run_vote(pack_list(d, l), lat);
      checks++;
      if (lat !== K + 1) begin failures++; $display("FAIL random%0d_latency got=%0d exp=%0d", n, lat, K + 1); end
      checks++;
      if ({int'(bus.label), int'(bus.votes), bus.valid, bus.bad_label} !== {e_lab, e_vot, e_val, e_bad}) begin
        failures++;
        $display("FAIL random%0d_result got label=%0d votes=%0d valid=%b bad=%b exp label=%0d votes=%0d valid=%b bad=%b",
                 n, bus.label, bus.votes, bus.valid, bus.bad_label, e_lab, e_vot, e_val, e_bad);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.done, int'(bus.label), int'(bus.votes), bus.valid} !== {1'b0, e_lab, e_vot, e_val}) begin
        failures++;
        $display("FAIL random%0d_hold got done=%b label=%0d votes=%0d valid=%b exp done=0 label=%0d votes=%0d valid=%b",
                 n, bus.done, bus.label, bus.votes, bus.valid, e_lab, e_vot, e_val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart_ignored();
    test_list_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
